// File: rtl/handshake_const_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_const_pkg
// Description : Shared constants for the handshake constant arbiter: the
//               requester count, the index width and the constant table.
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_const_pkg;

    // Number of requester control channels. The round-robin logic assumes 4.
    localparam int N_REQ   = 4;

    // Width of a requester index.
    localparam int IDX_W   = 2;

    // Native width of the table entries. The top resizes them to DATA_WIDTH.
    localparam int CONST_W = 30;

    typedef logic [IDX_W-1:0] idx_t;

    // One constant token per requester. Entry i is returned when requester i wins.
    localparam logic [N_REQ-1:0][CONST_W-1:0] CONST_TABLE = {
        30'h15555555,   // [3]
        30'h3FFFFFFF,   // [2]
        30'h00000000,   // [1]
        30'h27EFCFB0    // [0]
    };

    // Pointer value after a grant: the search starts just past the winner, so
    // the winner drops to lowest priority on the next arbitration.
    function automatic idx_t next_ptr(input idx_t winner);
        return winner + idx_t'(1);
    endfunction

endpackage : handshake_const_pkg
`default_nettype wire

// File: rtl/handshake_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : handshake_rr_picker
// Description : Combinational round-robin priority select. It searches the
//               valid vector starting at ptr and wrapping modulo N_REQ, and
//               returns the first set index plus an any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_rr_picker
    import handshake_const_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Scan the offsets ptr, ptr+1, ... with wrap-around. The first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        winner  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ptr + IDX_W'(k);
            if (!w_found && valid[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
        any_valid = |valid;
    end

endmodule : handshake_rr_picker
`default_nettype wire

// File: rtl/handshake_const_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : handshake_const_arbiter
// Description : Round-robin arbiter over N_REQ valid/ready control channels.
//               Each accepted request loads the requester's constant into a
//               single output slot. The slot drains and reloads in the same
//               cycle, so throughput is one token per cycle. A 16-bit counter
//               tracks the number of accepted tokens.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_const_arbiter
    import handshake_const_pkg::*;
#(
    parameter int DATA_WIDTH = 30,
    parameter int N_REQ      = handshake_const_pkg::N_REQ
)(
    input  logic                  clk,
    input  logic                  rst,          // synchronous, active-low
    input  logic [N_REQ-1:0]      ctrl_valid,
    output logic [N_REQ-1:0]      ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [1:0]            outs_index,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [15:0]           grant_count
);

    // Output slot, round-robin pointer and the grant counter.
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_index;
    logic [IDX_W-1:0]      r_ptr;
    logic [15:0]           r_count;

    logic [IDX_W-1:0]      w_winner;
    logic                  w_any_valid;
    logic                  w_slot_free;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_const;

    handshake_rr_picker u_picker (
        .valid     (ctrl_valid),
        .ptr       (r_ptr),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    // A slot is free if it is empty or is being drained this cycle. Loads are
    // blocked while reset is asserted, so no requester is acknowledged then.
    assign w_slot_free = !r_full || outs_ready;
    assign w_load      = rst && w_slot_free && w_any_valid;
    assign w_const     = DATA_WIDTH'(CONST_TABLE[w_winner]);

    // Acknowledge only the winning requester, and only when its token is taken.
    always_comb begin
        ctrl_ready = '0;
        if (w_load) begin
            ctrl_ready[w_winner] = 1'b1;
        end
    end

    // Slot, pointer and counter update. When a load and a drain happen in the
    // same cycle, the load takes priority and the slot stays full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full  <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_full  <= 1'b1;
            r_data  <= w_const;
            r_index <= w_winner;
            r_ptr   <= next_ptr(w_winner);
            r_count <= r_count + 16'd1;
        end else if (r_full && outs_ready) begin
            r_full  <= 1'b0;
        end
    end

    assign outs        = r_data;
    assign outs_index  = r_index;
    assign outs_valid  = r_full;
    assign grant_count = r_count;

endmodule : handshake_const_arbiter
`default_nettype wire

// File: tb/tb_handshake_const_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_const_arbiter
// Description : Self-checking bench. A reference model computes the expected
//               grant for each cycle and pushes the expected token into a
//               queue. Tokens are popped and compared when the DUT drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_const_arbiter;

    localparam int DW = 30;

    logic          clk;
    logic          r_rst;
    logic [3:0]    r_ctrl_valid;
    logic          r_outs_ready;
    logic [3:0]    w_ctrl_ready;
    logic [DW-1:0] w_outs;
    logic [1:0]    w_outs_index;
    logic          w_outs_valid;
    logic [15:0]   w_grant_count;

    handshake_const_arbiter #(.DATA_WIDTH(DW), .N_REQ(4)) dut (
        .clk         (clk),
        .rst         (r_rst),
        .ctrl_valid  (r_ctrl_valid),
        .ctrl_ready  (w_ctrl_ready),
        .outs        (w_outs),
        .outs_index  (w_outs_index),
        .outs_valid  (w_outs_valid),
        .outs_ready  (r_outs_ready),
        .grant_count (w_grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected constants, written independently of the design package.
    logic [DW-1:0] c_tbl [4];
    initial begin
        c_tbl[0] = 30'h27EFCFB0;
        c_tbl[1] = 30'h00000000;
        c_tbl[2] = 30'h3FFFFFFF;
        c_tbl[3] = 30'h15555555;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state and the scoreboard.
    logic          m_full = 1'b0;
    logic [1:0]    m_ptr  = 2'd0;
    logic [15:0]   m_cnt  = 16'd0;
    logic [DW-1:0] q_data [$];
    logic [1:0]    q_idx  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive the inputs, check the DUT against the model, advance
    // the model, then move to the next falling edge.
    task automatic step(input logic [3:0] cv, input logic ordy, input logic do_checks);
        logic       load;
        logic [1:0] win;
        logic       found;
        logic [3:0] exp_rdy;
        r_ctrl_valid = cv;
        r_outs_ready = ordy;
        #1;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = m_ptr + 2'(k);
            if (!found && cv[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        load    = r_rst && (!m_full || ordy) && found;
        exp_rdy = load ? (4'b0001 << win) : 4'b0000;
        if (do_checks) begin
            chk("ctrl_ready", 32'(w_ctrl_ready), 32'(exp_rdy));
            chk("outs_valid", 32'(w_outs_valid), 32'(m_full));
            chk("grant_count", 32'(w_grant_count), 32'(m_cnt));
            if (m_full) begin
                if (q_data.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    chk("outs", 32'(w_outs), 32'(q_data[0]));
                    chk("outs_index", 32'(w_outs_index), 32'(q_idx[0]));
                end
            end
        end
        if (!r_rst) begin
            m_full = 1'b0;
            m_ptr  = 2'd0;
            m_cnt  = 16'd0;
            q_data.delete();
            q_idx.delete();
        end else begin
            if (m_full && ordy && q_data.size() != 0) begin
                void'(q_data.pop_front());
                void'(q_idx.pop_front());
            end
            if (load) begin
                q_data.push_back(c_tbl[win]);
                q_idx.push_back(win);
                m_full = 1'b1;
                m_ptr  = win + 2'd1;
                m_cnt  = m_cnt + 16'd1;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        r_rst        = 1'b0;
        r_ctrl_valid = 4'b0000;
        r_outs_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // State while reset is held.
        chk("rst_outs_valid", 32'(w_outs_valid), 32'd0);
        chk("rst_outs", 32'(w_outs), 32'd0);
        chk("rst_outs_index", 32'(w_outs_index), 32'd0);
        chk("rst_grant_count", 32'(w_grant_count), 32'd0);
        step(4'b1111, 1'b1, 1'b1);          // ready must stay low in reset

        // Release reset. The first cycle can load. Requester 0 alone, then drain.
        r_rst = 1'b1;
        step(4'b0001, 1'b1, 1'b1);
        chk("single_outs", 32'(w_outs), 32'h27EFCFB0);
        chk("single_index", 32'(w_outs_index), 32'd0);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);          // idle: state holds

        // All requesters held: rotation and one token per cycle.
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b1);

        // Backpressure: the token is held stable and ready is low. On release,
        // drain and load happen in the same cycle.
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        // Wrap of the pointer from 3: grant 2 first so that ptr is 3, then
        // 1001 must grant 3, then 0.
        step(4'b0100, 1'b1, 1'b1);
        step(4'b1001, 1'b1, 1'b1);
        chk("wrap_first_idx", 32'(w_outs_index), 32'd3);
        step(4'b1001, 1'b1, 1'b1);
        chk("wrap_second_idx", 32'(w_outs_index), 32'd0);
        step(4'b0000, 1'b1, 1'b1);

        // Random mix of requests and backpressure.
        for (int i = 0; i < 200; i++)
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);

        // Reset while a token is held. The token is discarded, and the first
        // grant after release goes to the lowest valid index.
        step(4'b0100, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        r_rst = 1'b0;
        step(4'b1010, 1'b0, 1'b1);
        r_rst = 1'b1;
        chk("post_rst_valid", 32'(w_outs_valid), 32'd0);
        chk("post_rst_count", 32'(w_grant_count), 32'd0);
        step(4'b1010, 1'b1, 1'b1);
        chk("post_rst_index", 32'(w_outs_index), 32'd1);

        // Counter wrap: reset, then 65536 back-to-back loads.
        r_rst = 1'b0;
        step(4'b0000, 1'b1, 1'b1);
        r_rst = 1'b1;
        for (int i = 0; i < 65536; i++) step(4'b1111, 1'b1, (i % 4096) < 8 || i > 65528);
        chk("grant_count_wrap", 32'(w_grant_count), 32'd0);
        step(4'b0000, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_handshake_const_arbiter
`default_nettype wire

// File: doc/handshake_const_arbiter.md
HANDSHAKE_CONST_ARBITER -- requirements
Module: handshake_const_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 30, width of every constant token.
REQ-002 Parameter N_REQ, fixed at 4, number of requester control channels.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-005 Port ctrl_valid  input  N_REQ  per-requester token request, bit i = requester i.
REQ-006 Port ctrl_ready  output  N_REQ  per-requester acceptance, at most one bit high per cycle.
REQ-007 Port outs  output  DATA_WIDTH  constant selected for the granted requester.
REQ-008 Port outs_index  output  2  index of the requester whose constant is in outs.
REQ-009 Port outs_valid  output  1  output token present.
REQ-010 Port outs_ready  input  1  downstream consumes the token when high together with outs_valid.
REQ-011 Port grant_count  output  16  total tokens accepted since reset.

Function
REQ-012 The block shall hold one output register slot (full flag, data, index).
REQ-013 Load enable shall be (!full || outs_ready) && (|ctrl_valid).
REQ-014 Round-robin pointer ptr (2 bits): winner = first i with ctrl_valid[i], searching ptr, ptr+1, ... modulo 4.
REQ-015 ctrl_ready[winner] shall be 1 only when the load enable is true; all other bits shall be 0, purely combinational from current inputs and state.
REQ-016 On load: data <= CONST_TABLE[winner], index <= winner, full <= 1, ptr <= winner+1 (wraps 3->0).
REQ-017 On outs_valid && outs_ready with no load: full <= 0. A simultaneous drain and load shall keep full = 1 with the new token (throughput 1 token/cycle).
REQ-018 outs_valid shall equal full; latency from ctrl handshake to outs_valid shall be exactly 1 cycle.
REQ-019 While outs_valid && !outs_ready, outs and outs_index shall stay stable, and ctrl_ready shall be all zeros.
REQ-020 ptr shall change only on a load; with no ctrl_valid bits set, the state shall hold.
REQ-021 grant_count shall increment by 1 per load and wrap from 16'hFFFF to 0.
REQ-022 A requester that keeps ctrl_valid high shall be served at least once every 4 loads (no starvation).

Reset
REQ-023 While rst = 0 at a clock edge: full = 0, outs = 0, outs_index = 0, ptr = 0, grant_count = 0.
REQ-024 During reset, ctrl_ready shall be all zeros; a token in flight shall be discarded, not delivered.
REQ-025 The first load after reset release shall be allowed in the first cycle with rst = 1.

Structure
REQ-026 Package handshake_const_pkg shall hold: N_REQ, IDX_W = 2, and CONST_TABLE.
REQ-027 CONST_TABLE (DATA_WIDTH each) shall contain: [0] = 30'h27EFCFB0, [1] = 30'h00000000, [2] = 30'h3FFFFFFF, [3] = 30'h15555555.
REQ-028 Sub-module handshake_rr_picker (combinational round-robin priority select) shall provide the winner index and an any-valid flag.

Verification
REQ-029 Only ctrl_valid = 4'b0001, outs_ready = 1 -> ctrl_ready = 4'b0001; next cycle outs = 30'h27EFCFB0, outs_index = 0, outs_valid = 1.
REQ-030 ctrl_valid = 4'b1111 held, outs_ready = 1 -> outs_index sequence 0, 1, 2, 3, 0 on consecutive cycles; grant_count increments by 1 each cycle.
REQ-031 outs_ready = 0 for 5 cycles with a token held -> outs and index stable, ctrl_ready = 0; on release, drain and load occur in the same cycle.
REQ-032 ptr = 3 with ctrl_valid = 4'b1001 -> requester 3 is granted, then requester 0.
REQ-033 rst = 0 asserted while full = 1 -> next cycle outs_valid = 0, grant_count = 0, and the first grant after release goes to the lowest valid index.
REQ-034 Force 65536 loads -> grant_count wraps to 0.
